// File: rtl/bsg_wormhole_gather.sv
// 2-to-1 wormhole merge toward the chain root; input 1 headers get coordinate+1 (hop count).
// Define BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN for fixed local (input 0) priority instead of round-robin.
module bsg_wormhole_gather #(
  parameter int unsigned flit_width_p = 16,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned cord_width_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [1:0]                   v_i,
  input  logic [1:0][flit_width_p-1:0] data_i,
  output logic [1:0]                   ready_and_o,
  output logic                         v_o,
  output logic [flit_width_p-1:0]      data_o,
  input  logic                         ready_and_i
);

  localparam logic [cord_width_p-1:0] cord_ovf_lp = {cord_width_p{1'b1}} - cord_width_p'(1);

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                   state_q, state_d;
  logic                     sel_q, sel_d;
  logic [len_width_p-1:0]   cnt_q, cnt_d;
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
`else
  logic                     last_grant_q, last_grant_d;
`endif

  logic                     grant;
  logic [len_width_p-1:0]   hdr_len;
  logic [cord_width_p-1:0]  hdr_cord;
  logic                     enq, deq;
  logic [flit_width_p-1:0]  enq_data;

  logic [1:0][flit_width_p-1:0] mem_q;
  logic                         wr_ptr_q, rd_ptr_q, full_q, empty_q;

  // Header arbitration between the two inputs
  always_comb begin
    grant = v_i[1];
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
    if (v_i == 2'b11) grant = 1'b0;
`else
    if (v_i == 2'b11) grant = ~last_grant_q;
`endif
    hdr_len  = data_i[grant][cord_width_p +: len_width_p];
    hdr_cord = data_i[grant][cord_width_p-1:0];
  end

  // Packet lock FSM, input handshake and header rewrite
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
`else
    last_grant_d = last_grant_q;
`endif
    ready_and_o = 2'b00;
    enq         = 1'b0;
    enq_data    = data_i[sel_q];
    case (state_q)
      e_idle: begin
        enq_data = data_i[grant];
        if (grant) enq_data[cord_width_p-1:0] = hdr_cord + cord_width_p'(1);
        if (|v_i) begin
          ready_and_o[grant] = ~full_q;
          enq                = ~full_q;
        end
        if (enq) begin
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
`else
          last_grant_d = grant;
`endif
          if (hdr_len != '0) begin
            state_d = e_busy;
            sel_d   = grant;
            cnt_d   = hdr_len;
          end
        end
      end
      e_busy: begin
        ready_and_o[sel_q] = ~full_q;
        enq                = v_i[sel_q] & ~full_q;
        if (enq) begin
          cnt_d = cnt_q - len_width_p'(1);
          if (cnt_q == len_width_p'(1)) state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
`else
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
`ifdef BSG_WORMHOLE_GATHER_LOCAL_PRIO_EN
`else
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Two-entry output FIFO; full/empty are registered so ready never sees ready_and_i
  assign deq    = ~empty_q & ready_and_i;
  assign v_o    = ~empty_q;
  assign data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (enq) wr_ptr_q <= ~wr_ptr_q;
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      if (enq && !deq) begin
        full_q  <= (~wr_ptr_q == rd_ptr_q);
        empty_q <= 1'b0;
      end else if (deq && !enq) begin
        empty_q <= (~rd_ptr_q == wr_ptr_q);
        full_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= enq_data;
  end

  // Flag a downstream header whose increment lands on the reserved all-ones coordinate
  always @(posedge clk_i) begin
    if (!reset_i && enq && (state_q == e_idle) && grant)
      assert (hdr_cord != cord_ovf_lp)
        else $warning("bsg_wormhole_gather: coordinate overflow, forwarding reserved all-ones coordinate");
  end

endmodule
